// File: rtl/frq_sweep_ctrl.sv
// Frequency-select sweep sequencer for the ROM-controlled divider.
// Steps f_select through [lo,hi], holding each code for a programmed number of divider output edges.
module frq_sweep_ctrl #(
    parameter int SEL_W   = 5,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [1:0]         mode,
    input  logic [SEL_W-1:0]   lo_sel,
    input  logic [SEL_W-1:0]   hi_sel,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               edge_tick,
    output logic [SEL_W-1:0]   f_select,
    output logic               sel_update,
    output logic               busy,
    output logic               done,
    output logic               err
);

    typedef enum logic [1:0] {IDLE, DWELL, DONE} state_t;
    typedef enum logic [1:0] {UP_ONCE = 2'b00, DOWN_ONCE = 2'b01,
                              PING_PONG = 2'b10, UP_WRAP = 2'b11} mode_t;

    state_t             state;
    mode_t              mode_q;
    logic [SEL_W-1:0]   lo_q;
    logic [SEL_W-1:0]   hi_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] count;
    logic               dir_down;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            mode_q     <= UP_ONCE;
            lo_q       <= '0;
            hi_q       <= '0;
            dwell_q    <= '0;
            count      <= '0;
            dir_down   <= 1'b0;
            f_select   <= '0;
            sel_update <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            sel_update <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            // abort also swallows a start presented while IDLE
            if (abort) begin
                if (state != IDLE) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    count <= '0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if ((lo_sel > hi_sel) || (dwell == '0)) begin
                                err <= 1'b1;
                            end else begin
                                mode_q     <= mode_t'(mode);
                                lo_q       <= lo_sel;
                                hi_q       <= hi_sel;
                                dwell_q    <= dwell;
                                count      <= '0;
                                dir_down   <= (mode == DOWN_ONCE);
                                f_select   <= (mode == DOWN_ONCE) ? hi_sel : lo_sel;
                                sel_update <= 1'b1;
                                busy       <= 1'b1;
                                state      <= DWELL;
                            end
                        end
                    end
                    DWELL: begin
                        if (edge_tick) begin
                            if (count == dwell_q - 1'b1) begin
                                count <= '0;
                                if (!dir_down) begin
                                    if (f_select < hi_q) begin
                                        f_select   <= f_select + 1'b1;
                                        sel_update <= 1'b1;
                                    end else begin
                                        case (mode_q)
                                            PING_PONG: begin
                                                // a single-code range just re-announces the same code
                                                if (lo_q != hi_q) begin
                                                    dir_down <= 1'b1;
                                                    f_select <= f_select - 1'b1;
                                                end
                                                sel_update <= 1'b1;
                                            end
                                            UP_WRAP: begin
                                                f_select   <= lo_q;
                                                sel_update <= 1'b1;
                                            end
                                            default: begin
                                                state <= DONE;
                                                busy  <= 1'b0;
                                                done  <= 1'b1;
                                            end
                                        endcase
                                    end
                                end else begin
                                    if (f_select > lo_q) begin
                                        f_select   <= f_select - 1'b1;
                                        sel_update <= 1'b1;
                                    end else if (mode_q == PING_PONG) begin
                                        if (lo_q != hi_q) begin
                                            dir_down <= 1'b0;
                                            f_select <= f_select + 1'b1;
                                        end
                                        sel_update <= 1'b1;
                                    end else begin
                                        state <= DONE;
                                        busy  <= 1'b0;
                                        done  <= 1'b1;
                                    end
                                end
                            end else begin
                                count <= count + 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
